// File: rtl/axis_frame_gen_if.sv
// rtl/axis_frame_gen_if.sv - AXI4-Stream video bundle between frame generator and sink
//
// Carries one pixel beat per transfer (tvalid && tready).
//   tdata  [DWID-1:0] pixel data
//   tuser             start-of-frame (pixel 0, line 0)
//   tlast             end-of-line
//   tvalid            beat valid
//   tready            sink ready
// master modport: the generator side; slave modport: the sink side.

interface axis_frame_gen_if #(
   parameter int DWID = 24
) ();
   logic [DWID-1:0] tdata;
   logic            tuser;
   logic            tlast;
   logic            tvalid;
   logic            tready;

   modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream video frame generator (VACT lines x HACT pixels)
//
// Emits frames with TUSER on the first pixel of a frame and TLAST on the last
// pixel of each line, separated by HBLANK idle cycles between lines and VBLANK
// idle cycles after each frame. Honours TREADY back-pressure; every output is
// driven straight from a flop.
//
// Optional feature macro: AXIS_FRAME_GEN_PATTERN_EN
//   defined   : TDATA = {line[11:0], pixel[11:0]} zero-extended to DWID
//   undefined : TDATA = COLOR zero-extended to DWID
//
// Ports:
//   ACLK       in   clock, rising edge
//   ARESETN    in   synchronous active-low reset
//   ENABLE     in   start/continue frame generation (sampled in IDLE and at end of VGAP)
//   AXIS       master modport of axis_frame_gen_if (tdata/tuser/tlast/tvalid out, tready in)
//   BUSY       out  high in any state other than IDLE
//   FRAME_CNT  out  completed frames, wraps 255 -> 0

module axis_frame_gen #(
   parameter int          DWID   = 24,
   parameter int          HACT   = 1920,
   parameter int          VACT   = 1080,
   parameter int          HBLANK = 280,
   parameter int          VBLANK = 45,
   parameter logic [23:0] COLOR  = 24'h808080
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic                     ENABLE,
   axis_frame_gen_if.master         AXIS,
   output logic                     BUSY,
   output logic [7:0]               FRAME_CNT
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LINE = 2'd1;
   localparam logic [1:0] S_HGAP = 2'd2;
   localparam logic [1:0] S_VGAP = 2'd3;

   localparam logic [11:0] PIX_LAST  = 12'(HACT - 1);
   localparam logic [11:0] LINE_LAST = 12'(VACT - 1);
   // Gap terminal counts; unused when the corresponding blank is 0.
   localparam logic [15:0] HGAP_LAST = 16'((HBLANK > 0) ? HBLANK - 1 : 0);
   localparam logic [15:0] VGAP_LAST = 16'((VBLANK > 0) ? VBLANK - 1 : 0);

   logic [1:0]      state_q, state_d;
   logic [11:0]     pixel_q, pixel_d;
   logic [11:0]     line_q, line_d;
   logic [15:0]     gap_q, gap_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;

   logic            tvalid_q, tvalid_d;
   logic            tuser_q, tuser_d;
   logic            tlast_q, tlast_d;
   logic [DWID-1:0] tdata_q, tdata_d;
   logic            busy_q, busy_d;

   logic            line_beat;
   logic [DWID-1:0] pix_val;

   // Next-state logic. In LINE tvalid_q is always 1, so tready alone marks a transfer.
   always_comb begin
      state_d     = state_q;
      pixel_d     = pixel_q;
      line_d      = line_q;
      gap_d       = gap_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (ENABLE) begin
               state_d = S_LINE;
               pixel_d = '0;
               line_d  = '0;
            end
         end
         S_LINE: begin
            if (AXIS.tready) begin
               if (pixel_q == PIX_LAST) begin
                  pixel_d = '0;
                  gap_d   = '0;
                  if (line_q == LINE_LAST) begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                     line_d      = '0;
                     // With no vertical blank the continue/stop decision is taken right here.
                     if (VBLANK != 0) state_d = S_VGAP;
                     else if (ENABLE) state_d = S_LINE;
                     else             state_d = S_IDLE;
                  end else begin
                     line_d  = line_q + 12'd1;
                     state_d = (HBLANK != 0) ? S_HGAP : S_LINE;
                  end
               end else begin
                  pixel_d = pixel_q + 12'd1;
               end
            end
         end
         S_HGAP: begin
            if (gap_q == HGAP_LAST) state_d = S_LINE;
            else                    gap_d   = gap_q + 16'd1;
         end
         S_VGAP: begin
            if (gap_q == VGAP_LAST) state_d = ENABLE ? S_LINE : S_IDLE;
            else                    gap_d   = gap_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef AXIS_FRAME_GEN_PATTERN_EN
   assign pix_val = DWID'({line_d, pixel_d});
`else
   assign pix_val = DWID'(COLOR);
`endif

   // Outputs are derived from the next state so they land in the same cycle as
   // the state they describe; a stalled beat recomputes identical values.
   always_comb begin
      line_beat = (state_d == S_LINE);
      tvalid_d  = line_beat;
      tuser_d   = line_beat && (pixel_d == 12'd0) && (line_d == 12'd0);
      tlast_d   = line_beat && (pixel_d == PIX_LAST);
      tdata_d   = line_beat ? pix_val : '0;
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         pixel_q     <= '0;
         line_q      <= '0;
         gap_q       <= '0;
         frame_cnt_q <= '0;
         tvalid_q    <= 1'b0;
         tuser_q     <= 1'b0;
         tlast_q     <= 1'b0;
         tdata_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pixel_q     <= pixel_d;
         line_q      <= line_d;
         gap_q       <= gap_d;
         frame_cnt_q <= frame_cnt_d;
         tvalid_q    <= tvalid_d;
         tuser_q     <= tuser_d;
         tlast_q     <= tlast_d;
         tdata_q     <= tdata_d;
         busy_q      <= busy_d;
      end
   end

   assign AXIS.tvalid = tvalid_q;
   assign AXIS.tuser  = tuser_q;
   assign AXIS.tlast  = tlast_q;
   assign AXIS.tdata  = tdata_q;
   assign BUSY        = busy_q;
   assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - directed self-checking bench for axis_frame_gen (4x3 frame, HBLANK=2, VBLANK=5)

module tb_axis_frame_gen;

   localparam int DW = 24;

`ifdef AXIS_FRAME_GEN_PATTERN_EN
   localparam logic [23:0] EXP_B6  = 24'h001001;
   localparam logic [23:0] EXP_B12 = 24'h002003;
`else
   localparam logic [23:0] EXP_B6  = 24'h808080;
   localparam logic [23:0] EXP_B12 = 24'h808080;
`endif

   logic       aclk = 1'b0;
   logic       aresetn;
   logic       enable;
   logic       busy;
   logic [7:0] frame_cnt;

   int checks   = 0;
   int failures = 0;

   axis_frame_gen_if #(.DWID(DW)) axis_if ();

   axis_frame_gen #(
      .DWID   (DW),
      .HACT   (4),
      .VACT   (3),
      .HBLANK (2),
      .VBLANK (5),
      .COLOR  (24'h808080)
   ) dut (
      .ACLK      (aclk),
      .ARESETN   (aresetn),
      .ENABLE    (enable),
      .AXIS      (axis_if),
      .BUSY      (busy),
      .FRAME_CNT (frame_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Expected pixel value for beat k (0..11) of a 4x3 frame.
   function automatic logic [23:0] exp_data(input int k);
`ifdef AXIS_FRAME_GEN_PATTERN_EN
      logic [11:0] ln;
      logic [11:0] px;
      ln = 12'(k / 4);
      px = 12'(k % 4);
      return {ln, px};
`else
      return 24'h808080;
`endif
   endfunction

   // Consume beats k0..k1-1 of a frame, checking markers, data and stall stability.
   task automatic run_beats(input string tag, input int k0, input int k1, input bit rnd);
      int          k;
      int          budget;
      bit          stalled;
      logic [23:0] pd;
      logic        pu;
      logic        pl;
      k       = k0;
      budget  = 400;
      stalled = 0;
      pd = '0; pu = 1'b0; pl = 1'b0;
      while (k < k1 && budget > 0) begin
         if (stalled) begin
            check({tag, "_hold_valid"}, 32'(axis_if.tvalid), 32'd1);
            check({tag, "_hold_data"},  32'(axis_if.tdata), 32'(pd));
            check({tag, "_hold_user"},  32'(axis_if.tuser), 32'(pu));
            check({tag, "_hold_last"},  32'(axis_if.tlast), 32'(pl));
         end
         axis_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 0;
         if (axis_if.tvalid) begin
            if (axis_if.tready) begin
               check({tag, "_tuser"}, 32'(axis_if.tuser), 32'(k == 0));
               check({tag, "_tlast"}, 32'(axis_if.tlast), 32'(k % 4 == 3));
               check({tag, "_tdata"}, 32'(axis_if.tdata), 32'(exp_data(k)));
               k++;
            end else begin
               stalled = 1;
               pd = axis_if.tdata;
               pu = axis_if.tuser;
               pl = axis_if.tlast;
            end
         end
         tick();
         budget--;
      end
      check({tag, "_beats"}, 32'(k), 32'(k1));
   endtask

   initial begin
      int beats;

      // Scenario 1: reset, then idle with ENABLE low.
      aresetn        = 1'b0;
      enable         = 1'b0;
      axis_if.tready = 1'b0;
      repeat (3) tick();
      check("s1_reset_outs", {axis_if.tvalid, axis_if.tuser, axis_if.tlast, busy, frame_cnt}, 32'd0);
      check("s1_reset_data", 32'(axis_if.tdata), 32'd0);
      aresetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("s1_idle", {axis_if.tvalid, axis_if.tuser, axis_if.tlast, busy, frame_cnt}, 32'd0);
      end

      // Scenario 2: full-rate frame timing.
      enable         = 1'b1;
      axis_if.tready = 1'b1;
      tick();
      check("s2_first_valid", 32'(axis_if.tvalid), 32'd1);
      check("s2_busy_rise", 32'(busy), 32'd1);
      beats = 0;
      for (int c = 0; c < 22; c++) begin
         if (c == 15) check("s2_fc_before", 32'(frame_cnt), 32'd0);
         if (c == 16) check("s2_fc_after", 32'(frame_cnt), 32'd1);
         if (axis_if.tvalid) begin
            if (beats < 12) begin
               check("s2_beat_cycle", 32'(c), 32'((beats / 4) * 6 + beats % 4));
               check("s2_tuser", 32'(axis_if.tuser), 32'(beats == 0));
               check("s2_tlast", 32'(axis_if.tlast), 32'(beats % 4 == 3));
               check("s2_tdata", 32'(axis_if.tdata), 32'(exp_data(beats)));
               if (beats == 5)  check("s2_tdata_b6", 32'(axis_if.tdata), 32'(EXP_B6));
               if (beats == 11) check("s2_tdata_b12", 32'(axis_if.tdata), 32'(EXP_B12));
            end else begin
               check("s2_next_sof_cycle", 32'(c), 32'd21);
               check("s2_next_tuser", 32'(axis_if.tuser), 32'd1);
            end
            beats++;
         end
         tick();
      end
      check("s2_beat_count", 32'(beats), 32'd13);

      // Scenario 3: random back-pressure over the rest of frame 2 and all of frame 3.
      run_beats("s3a", 1, 12, 1'b1);
      check("s3_fc2", 32'(frame_cnt), 32'd2);
      run_beats("s3b", 0, 12, 1'b1);
      check("s3_fc3", 32'(frame_cnt), 32'd3);

      // Scenario 4: ENABLE dropped mid-frame; frame completes then IDLE.
      run_beats("s4a", 0, 5, 1'b0);
      enable = 1'b0;
      run_beats("s4b", 5, 12, 1'b0);
      check("s4_fc", 32'(frame_cnt), 32'd4);
      for (int i = 0; i < 5; i++) begin
         check("s4_vgap_valid", 32'(axis_if.tvalid), 32'd0);
         check("s4_vgap_busy", 32'(busy), 32'd1);
         tick();
      end
      check("s4_idle_busy", 32'(busy), 32'd0);
      check("s4_idle_valid", 32'(axis_if.tvalid), 32'd0);
      repeat (3) tick();
      check("s4_idle_stay", {axis_if.tvalid, busy, frame_cnt}, 32'd4);

      // Scenario 5: one-cycle reset at beat 6.
      enable = 1'b1;
      run_beats("s5a", 0, 5, 1'b0);
      aresetn = 1'b0;
      tick();
      check("s5_rst_valid", 32'(axis_if.tvalid), 32'd0);
      check("s5_rst_fc", 32'(frame_cnt), 32'd0);
      check("s5_rst_busy", 32'(busy), 32'd0);
      aresetn = 1'b1;
      tick();
      check("s5_restart_valid", 32'(axis_if.tvalid), 32'd1);
      check("s5_restart_tuser", 32'(axis_if.tuser), 32'd1);
`ifdef AXIS_FRAME_GEN_PATTERN_EN
      check("s5_restart_tdata", 32'(axis_if.tdata), 32'd0);
`else
      check("s5_restart_tdata", 32'(axis_if.tdata), 32'h808080);
`endif
      run_beats("s5b", 0, 12, 1'b0);
      check("s5_fc", 32'(frame_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
